vec_cache_rd_edge_port: RTL and testbench
=========================================

Name: vec_cache_rd_edge_port

Overview:
- Read-side edge agent for one lane of a vec_cache switch row.
- Accepts read requests from upstream with valid/ready, tags each one with a slot id and its direction, and injects it as a read command into the switch row. The row has no backpressure.
- Collects returned read data from the row. Data may arrive out of order because different SRAM blocks in the row have different return distances.
- Retires data to downstream strictly in request order through a small reorder buffer.
- One instance per lane (8 per row edge).

Parameters:
- DEPTH, 8, reorder slots (power of 2), max outstanding reads.
- TAG_W, 3, slot-tag width; must equal $clog2(DEPTH).
- DIR_ID, `VEC_CACHE_WEST, 2-bit direction code written into txn_id.direction_id.
- TIMEOUT_CYC, 1023, used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_vld  in  1  upstream read request valid.
- req_rdy  out  1  request accepted when req_vld && req_rdy.
- req_pld  in  $bits(arb_out_req_t)  request payload.
- read_cmd_out_vld  out  1  command into the switch row.
- read_cmd_out_pld  out  $bits(arb_out_req_t)  tagged command.
- data_in_vld  in  1  returned data valid from the row.
- data_in  in  $bits(data_pld_t)  returned data; carries the echoed cmd_pld.
- resp_vld  out  1  in-order response valid.
- resp_rdy  in  1  downstream ready.
- resp_pld  out  $bits(data_pld_t)  response data.
- outstanding_cnt  out  TAG_W+1  allocated slots not yet retired.
- err_unexp_resp  out  1  sticky; set by an unexpected response.
- timeout_err  out  1  sticky; driven only with the optional feature.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: read_cmd_out_vld=0, read_cmd_out_pld=0, resp_vld=0, outstanding_cnt=0, err_unexp_resp=0, timeout_err=0.
  - State: all slots FREE, wr_ptr=0, rd_ptr=0, timeout counter 0.
  - Reset mid-operation discards all in-flight slots. Responses returning after reset hit FREE slots and set err_unexp_resp.
- Slot state per tag: FREE -> PEND on allocate; PEND -> DONE on matching data; DONE -> FREE on retire. No other transitions.
- Pointers:
  - wr_ptr and rd_ptr are TAG_W+1 bits and wrap naturally.
  - empty = (wr_ptr == rd_ptr).
  - full = (MSBs differ && low TAG_W bits equal).
- Allocate:
  - req_rdy = !full, from registers only; there is no same-cycle bypass from a retire.
  - On accept, slot[wr_ptr[TAG_W-1:0]] becomes PEND and wr_ptr increments.
  - Next cycle (latency 1): read_cmd_out_vld=1 and read_cmd_out_pld = req_pld, with txn_id.direction_id=DIR_ID and txn_id.req_id[TAG_W-1:0]=allocated tag.
  - read_cmd_out_vld returns to 0 in any cycle without an accept.
- Capture, when data_in_vld=1:
  - Data whose direction_id != DIR_ID is ignored silently.
  - Otherwise tag = data_in.cmd_pld.txn_id.req_id[TAG_W-1:0].
  - If slot[tag]==PEND: buf[tag] <= data_in and the slot becomes DONE.
  - If the slot is FREE or DONE: data is dropped and err_unexp_resp <= 1. It stays set until reset.
- Retire:
  - resp_vld = !empty && slot[rd_ptr]==DONE.
  - resp_pld = buf[rd_ptr] (mux from registers).
  - On resp_vld && resp_rdy: the slot becomes FREE and rd_ptr increments.
  - resp_pld must stay stable while resp_vld && !resp_rdy.
  - A younger DONE slot never bypasses an older PEND slot.
- Simultaneous events:
  - Allocate, capture and retire may all occur in one cycle; each acts on a distinct slot.
  - Capture into a slot in the same cycle it is allocated cannot occur: the command leaves one cycle later and the round trip is at least 2 cycles.
- outstanding_cnt = wr_ptr - rd_ptr, modulo 2^(TAG_W+1). Range 0..DEPTH.

Optional Feature:
- Macro: VEC_CACHE_RD_TIMEOUT_EN.
- When defined:
  - A counter of width $clog2(TIMEOUT_CYC+1) increments every cycle that !empty && slot[rd_ptr]==PEND.
  - It clears on retire, or when the oldest slot is not PEND.
  - When the counter reaches TIMEOUT_CYC, timeout_err <= 1 (sticky). The counter saturates; slot state is not modified.
- When undefined: the counter logic is absent and timeout_err is tied to 0.

Test Plan:
- Single read: accept one req at cycle 0 -> read_cmd_out_vld=1 at cycle 1 with req_id=0 and direction_id=DIR_ID. Return data at cycle 5 -> resp_vld=1 at cycle 6, then outstanding_cnt goes 1->0 after retire.
- Out-of-order return: issue tags 0,1,2, return 2,0,1 -> responses retire in order 0,1,2. resp_vld stays 0 until tag 0 has arrived.
- Full: 8 accepts with no returns -> req_rdy=0 and outstanding_cnt=8. Return and retire tag 0 -> req_rdy=1 next cycle; the 9th request gets tag 0 and wr_ptr wraps to MSB=1.
- Backpressure and concurrency: resp_rdy=0 for 4 cycles with DONE data -> resp_pld is stable and no slot is lost. In one cycle, allocate tag 3, capture tag 1 and retire tag 0 -> all three occur.
- Errors: return tag 5 while slot 5 is FREE -> err_unexp_resp=1 and no resp_vld. Return data with direction_id=`VEC_CACHE_NORTH -> ignored, no error. Assert reset with 3 outstanding, then return them -> err_unexp_resp=1.
- Timeout (macro defined, TIMEOUT_CYC=16): issue one read and never return it -> timeout_err=1 sixteen cycles after the slot is PEND at the head. With the macro undefined, timeout_err stays 0.

Source files
------------

// File: rtl/vec_cache_rd_edge_port.sv
// -----------------------------------------------------------------------------
// vec_cache_rd_edge_port
//
// Read-side edge agent for one lane of a vec_cache switch row.
//
// Upstream read requests are accepted with valid/ready. Each request is given
// a reorder slot. Its slot id and this port's direction code are written into
// the txn_id field, and it goes into the switch row as a read command one cycle
// later. The row cannot apply backpressure, so the slot count alone limits
// how many reads are outstanding.
//
// The row can return data out of order, because SRAM blocks sit at different
// distances. The echoed txn_id of each return selects its slot. Data leaves
// downstream strictly in request order from the head of a circular reorder
// buffer.
//
// Slot life cycle: FREE -> PEND (allocate) -> DONE (data) -> FREE (retire).
//
// Ports
//   clk               clock
//   rst_n             asynchronous active-low reset
//   req_vld/req_rdy   upstream request handshake
//   req_pld           request payload (arb_out_req_t layout, see below)
//   read_cmd_out_vld  tagged read command into the switch row
//   read_cmd_out_pld  tagged command payload
//   data_in_vld       returned data valid from the row
//   data_in           returned data (data_pld_t layout, carries echoed cmd)
//   resp_vld/resp_rdy in-order response handshake to downstream
//   resp_pld          response payload (data_pld_t layout)
//   outstanding_cnt   slots allocated and not yet retired (0..DEPTH)
//   err_unexp_resp    sticky: a return hit a FREE or DONE slot
//   timeout_err       sticky: head slot waited TIMEOUT_CYC cycles
//
// Payload layouts (MSB first)
//   arb_out_req_t : { txn_id{direction_id[1:0], req_id[7:0]}, addr[23:0] }
//   data_pld_t    : { cmd_pld(arb_out_req_t), data[31:0] }
//
// Optional feature
//   VEC_CACHE_RD_TIMEOUT_EN : when defined, adds the head-of-line timeout
//   watchdog that drives timeout_err. When undefined, timeout_err is 0.
// -----------------------------------------------------------------------------

`ifndef VEC_CACHE_NORTH
`define VEC_CACHE_NORTH 2'd0
`endif
`ifndef VEC_CACHE_EAST
`define VEC_CACHE_EAST 2'd1
`endif
`ifndef VEC_CACHE_SOUTH
`define VEC_CACHE_SOUTH 2'd2
`endif
`ifndef VEC_CACHE_WEST
`define VEC_CACHE_WEST 2'd3
`endif

module vec_cache_rd_edge_port #(
  parameter int         DEPTH       = 8,
  parameter int         TAG_W       = 3,
  parameter logic [1:0] DIR_ID      = `VEC_CACHE_WEST,
  parameter int         TIMEOUT_CYC = 1023,
  localparam int        ADDR_W      = 24,
  localparam int        REQ_ID_W    = 8,
  localparam int        REQ_W       = 2 + REQ_ID_W + ADDR_W,
  localparam int        DATA_W      = 32,
  localparam int        PLD_W       = REQ_W + DATA_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_vld,
  output logic               req_rdy,
  input  logic [REQ_W-1:0]   req_pld,
  output logic               read_cmd_out_vld,
  output logic [REQ_W-1:0]   read_cmd_out_pld,
  input  logic               data_in_vld,
  input  logic [PLD_W-1:0]   data_in,
  output logic               resp_vld,
  input  logic               resp_rdy,
  output logic [PLD_W-1:0]   resp_pld,
  output logic [TAG_W:0]     outstanding_cnt,
  output logic               err_unexp_resp,
  output logic               timeout_err
);

  typedef struct packed {
    logic [1:0]          direction_id;
    logic [REQ_ID_W-1:0] req_id;
  } txn_id_t;

  typedef struct packed {
    txn_id_t             txn_id;
    logic [ADDR_W-1:0]   addr;
  } arb_out_req_t;

  typedef struct packed {
    arb_out_req_t        cmd_pld;
    logic [DATA_W-1:0]   data;
  } data_pld_t;

  typedef enum logic [1:0] {
    SLOT_FREE = 2'd0,
    SLOT_PEND = 2'd1,
    SLOT_DONE = 2'd2
  } slot_state_t;

  // ---------------------------------------------------------------------------
  // Pointers and occupancy
  // ---------------------------------------------------------------------------
  // One extra MSB on each pointer tells full apart from empty when the
  // slot indices are equal.
  logic [TAG_W:0]   wr_ptr_reg;
  logic [TAG_W:0]   rd_ptr_reg;
  logic [TAG_W-1:0] wr_idx;
  logic [TAG_W-1:0] rd_idx;
  logic             empty;
  logic             full;
  logic             accept;
  logic             retire;

  assign wr_idx = wr_ptr_reg[TAG_W-1:0];
  assign rd_idx = rd_ptr_reg[TAG_W-1:0];
  assign empty  = (wr_ptr_reg == rd_ptr_reg);
  assign full   = (wr_ptr_reg[TAG_W] != rd_ptr_reg[TAG_W]) && (wr_idx == rd_idx);

  // Ready depends on registered state only. A slot freed by a retire
  // becomes usable on the following cycle.
  assign req_rdy = !full;
  assign accept  = req_vld && !full;

  assign outstanding_cnt = wr_ptr_reg - rd_ptr_reg;

  // ---------------------------------------------------------------------------
  // Capture decode
  // ---------------------------------------------------------------------------
  data_pld_t        cap_in;
  logic             cap_vld;
  logic [TAG_W-1:0] cap_tag;
  logic             cap_ok;
  logic [DEPTH-1:0] pend_vec;
  logic [DEPTH-1:0] done_vec;

  assign cap_in  = data_pld_t'(data_in);
  // Returns for other lanes' directions share the row bus; they are not ours.
  assign cap_vld = data_in_vld && (cap_in.cmd_pld.txn_id.direction_id == DIR_ID);
  assign cap_tag = cap_in.cmd_pld.txn_id.req_id[TAG_W-1:0];
  assign cap_ok  = pend_vec[cap_tag];

  // ---------------------------------------------------------------------------
  // Retire decode
  // ---------------------------------------------------------------------------
  // Only the head slot can retire, so a DONE slot behind a PEND head waits.
  assign resp_vld = !empty && done_vec[rd_idx];
  assign retire   = resp_vld && resp_rdy;

  // ---------------------------------------------------------------------------
  // Per-slot state machines
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      slot_state_t state_reg;
      slot_state_t state_next;
      logic        alloc_hit;
      logic        cap_hit;
      logic        ret_hit;

      assign alloc_hit = accept && (wr_idx == TAG_W'(gi));
      assign cap_hit   = cap_vld && (cap_tag == TAG_W'(gi));
      assign ret_hit   = retire && (rd_idx == TAG_W'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_reg <= SLOT_FREE;
        end else begin
          state_reg <= state_next;
        end
      end

      always_comb begin
        state_next = state_reg;
        unique case (state_reg)
          SLOT_FREE: if (alloc_hit) state_next = SLOT_PEND;
          SLOT_PEND: if (cap_hit)   state_next = SLOT_DONE;
          SLOT_DONE: if (ret_hit)   state_next = SLOT_FREE;
          default:                  state_next = SLOT_FREE;
        endcase
      end

      assign pend_vec[gi] = (state_reg == SLOT_PEND);
      assign done_vec[gi] = (state_reg == SLOT_DONE);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Reorder data storage
  // ---------------------------------------------------------------------------
  // The buffer is written only on a valid capture. It is read by the head
  // pointer, which cannot move while resp_vld is held without resp_rdy, so
  // resp_pld stays stable under backpressure.
  data_pld_t data_buf_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (cap_vld && cap_ok) begin
      data_buf_reg[cap_tag] <= cap_in;
    end
  end

  assign resp_pld = data_buf_reg[rd_idx];

  // ---------------------------------------------------------------------------
  // Pointer registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (accept) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (retire) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Command injection
  // ---------------------------------------------------------------------------
  // Upper req_id bits from upstream pass through unchanged. Only the slot
  // tag bits and the direction code are overwritten.
  arb_out_req_t cmd_next;
  arb_out_req_t cmd_reg;
  logic         cmd_vld_reg;

  always_comb begin
    cmd_next                           = arb_out_req_t'(req_pld);
    cmd_next.txn_id.direction_id       = DIR_ID;
    cmd_next.txn_id.req_id[TAG_W-1:0]  = wr_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_vld_reg <= 1'b0;
      cmd_reg     <= '0;
    end else begin
      cmd_vld_reg <= accept;
      if (accept) cmd_reg <= cmd_next;
    end
  end

  assign read_cmd_out_vld = cmd_vld_reg;
  assign read_cmd_out_pld = cmd_reg;

  // ---------------------------------------------------------------------------
  // Unexpected-response error (sticky until reset)
  // ---------------------------------------------------------------------------
  // This also catches returns from reads that were in flight across a reset.
  // Those returns land on FREE slots.
  logic err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else if (cap_vld && !cap_ok) begin
      err_reg <= 1'b1;
    end
  end

  assign err_unexp_resp = err_reg;

  // ---------------------------------------------------------------------------
  // Head-of-line timeout watchdog
  // ---------------------------------------------------------------------------
`ifdef VEC_CACHE_RD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] to_cnt_reg;
  logic            to_err_reg;
  logic            head_pend;

  assign head_pend = !empty && pend_vec[rd_idx];

  // The counter saturates at TIMEOUT_CYC. The error flags on the same edge
  // that the counter reaches the limit. Slot state is never touched, so a
  // late return still retires normally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_reg <= '0;
      to_err_reg <= 1'b0;
    end else if (retire || !head_pend) begin
      to_cnt_reg <= '0;
    end else if (to_cnt_reg != TO_W'(TIMEOUT_CYC)) begin
      to_cnt_reg <= to_cnt_reg + 1'b1;
      if (to_cnt_reg == TO_W'(TIMEOUT_CYC - 1)) begin
        to_err_reg <= 1'b1;
      end
    end
  end

  assign timeout_err = to_err_reg;
`else
  logic [31:0] unused_timeout_cfg;

  assign unused_timeout_cfg = 32'(TIMEOUT_CYC);
  assign timeout_err        = 1'b0;
`endif

endmodule

// File: tb/tb_vec_cache_rd_edge_port.sv
// -----------------------------------------------------------------------------
// tb_vec_cache_rd_edge_port
//
// Directed bench for vec_cache_rd_edge_port. A table of per-cycle vectors
// exercises single and out-of-order reads. Hand-written sequences cover full,
// backpressure, concurrency, error, reset and timeout behaviour. Outputs are
// sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_vec_cache_rd_edge_port;

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_U = 2'd1;   // arbitrary upstream direction bits
  localparam logic [1:0] DIR_W = 2'd3;
`ifdef VEC_CACHE_RD_TIMEOUT_EN
  localparam bit EXP_TO = 1'b1;
`else
  localparam bit EXP_TO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_vld = 1'b0;
  logic        req_rdy;
  logic [33:0] req_pld = '0;
  logic        read_cmd_out_vld;
  logic [33:0] read_cmd_out_pld;
  logic        data_in_vld = 1'b0;
  logic [65:0] data_in = '0;
  logic        resp_vld;
  logic        resp_rdy = 1'b0;
  logic [65:0] resp_pld;
  logic [3:0]  outstanding_cnt;
  logic        err_unexp_resp;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vec_cache_rd_edge_port #(.TIMEOUT_CYC(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_vld          (req_vld),
    .req_rdy          (req_rdy),
    .req_pld          (req_pld),
    .read_cmd_out_vld (read_cmd_out_vld),
    .read_cmd_out_pld (read_cmd_out_pld),
    .data_in_vld      (data_in_vld),
    .data_in          (data_in),
    .resp_vld         (resp_vld),
    .resp_rdy         (resp_rdy),
    .resp_pld         (resp_pld),
    .outstanding_cnt  (outstanding_cnt),
    .err_unexp_resp   (err_unexp_resp),
    .timeout_err      (timeout_err)
  );

  // req_id upper bits 5'b01011 must pass through; low 3 bits carry the tag.
  function automatic logic [33:0] mk_cmd(logic [1:0] dir, logic [2:0] tag, logic [23:0] addr);
    return {dir, 5'b01011, tag, addr};
  endfunction

  function automatic logic [65:0] mk_data(logic [1:0] dir, logic [2:0] tag, logic [31:0] val);
    return {mk_cmd(dir, tag, 24'h0), val};
  endfunction

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_vld     = 1'b0;
    data_in_vld = 1'b0;
    resp_rdy    = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_cmd_vld", read_cmd_out_vld, 0);
    chk("rst_cmd_pld", read_cmd_out_pld, 0);
    chk("rst_resp_vld", resp_vld, 0);
    chk("rst_cnt", outstanding_cnt, 0);
    chk("rst_err", err_unexp_resp, 0);
    chk("rst_to", timeout_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic send_req(input logic [23:0] addr);
    req_vld = 1'b1;
    req_pld = mk_cmd(DIR_U, 3'd7, addr);
    $display("req addr=%h rdy=%0b", addr, req_rdy);
    step();
    req_vld = 1'b0;
  endtask

  task automatic send_data(input logic [1:0] dir, input logic [2:0] tag, input logic [31:0] val);
    data_in_vld = 1'b1;
    data_in     = mk_data(dir, tag, val);
    $display("return dir=%0d tag=%0d val=%h", dir, tag, val);
    step();
    data_in_vld = 1'b0;
  endtask

  typedef struct {
    bit          rv;     // req_vld
    logic [23:0] addr;   // request address
    bit          dv;     // data_in_vld (west)
    logic [2:0]  dt;     // returned tag
    logic [31:0] dval;   // returned data
    bit          rr;     // resp_rdy
    bit          e_rdy;
    bit          e_cv;
    logic [2:0]  e_ct;
    logic [23:0] e_ca;
    bit          e_rsv;
    logic [2:0]  e_rt;
    logic [31:0] e_rval;
    logic [3:0]  e_cnt;
    bit          e_err;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  // Expected columns describe outputs before this row's inputs are applied.
  initial begin
    //          rv  addr      dv dt   dval          rr  rdy cv ct  caddr     rsv rt  rval          cnt err
    vecs[0]  = '{1, 24'h100, 0, 0, 32'h0,        0,  1, 0, 0, 24'h0,   0, 0, 32'h0,        0, 0};
    vecs[1]  = '{0, 24'h0,   0, 0, 32'h0,        0,  1, 1, 0, 24'h100, 0, 0, 32'h0,        1, 0};
    vecs[2]  = '{0, 24'h0,   0, 0, 32'h0,        0,  1, 0, 0, 24'h0,   0, 0, 32'h0,        1, 0};
    vecs[3]  = '{0, 24'h0,   0, 0, 32'h0,        0,  1, 0, 0, 24'h0,   0, 0, 32'h0,        1, 0};
    vecs[4]  = '{0, 24'h0,   0, 0, 32'h0,        0,  1, 0, 0, 24'h0,   0, 0, 32'h0,        1, 0};
    vecs[5]  = '{0, 24'h0,   1, 0, 32'hCAFE0000, 0,  1, 0, 0, 24'h0,   0, 0, 32'h0,        1, 0};
    vecs[6]  = '{0, 24'h0,   0, 0, 32'h0,        1,  1, 0, 0, 24'h0,   1, 0, 32'hCAFE0000, 1, 0};
    vecs[7]  = '{1, 24'h101, 0, 0, 32'h0,        0,  1, 0, 0, 24'h0,   0, 0, 32'h0,        0, 0};
    vecs[8]  = '{1, 24'h102, 0, 0, 32'h0,        0,  1, 1, 1, 24'h101, 0, 0, 32'h0,        1, 0};
    vecs[9]  = '{1, 24'h103, 0, 0, 32'h0,        0,  1, 1, 2, 24'h102, 0, 0, 32'h0,        2, 0};
    vecs[10] = '{0, 24'h0,   1, 3, 32'hCAFE0003, 0,  1, 1, 3, 24'h103, 0, 0, 32'h0,        3, 0};
    vecs[11] = '{0, 24'h0,   1, 1, 32'hCAFE0001, 0,  1, 0, 0, 24'h0,   0, 0, 32'h0,        3, 0};
    vecs[12] = '{0, 24'h0,   1, 2, 32'hCAFE0002, 1,  1, 0, 0, 24'h0,   1, 1, 32'hCAFE0001, 3, 0};
    vecs[13] = '{0, 24'h0,   0, 0, 32'h0,        1,  1, 0, 0, 24'h0,   1, 2, 32'hCAFE0002, 2, 0};
    vecs[14] = '{0, 24'h0,   0, 0, 32'h0,        1,  1, 0, 0, 24'h0,   1, 3, 32'hCAFE0003, 1, 0};
    vecs[15] = '{0, 24'h0,   0, 0, 32'h0,        0,  1, 0, 0, 24'h0,   0, 0, 32'h0,        0, 0};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t t;
    do_reset();

    // ---------------- table: single read and out-of-order return ----------
    for (int i = 0; i < NV; i++) begin
      t = vecs[i];
      chk($sformatf("v%0d_req_rdy", i), req_rdy, t.e_rdy);
      chk($sformatf("v%0d_cmd_vld", i), read_cmd_out_vld, t.e_cv);
      if (t.e_cv) chk($sformatf("v%0d_cmd_pld", i), read_cmd_out_pld, mk_cmd(DIR_W, t.e_ct, t.e_ca));
      chk($sformatf("v%0d_resp_vld", i), resp_vld, t.e_rsv);
      if (t.e_rsv) chk($sformatf("v%0d_resp_pld", i), resp_pld, mk_data(DIR_W, t.e_rt, t.e_rval));
      chk($sformatf("v%0d_cnt", i), outstanding_cnt, t.e_cnt);
      chk($sformatf("v%0d_err", i), err_unexp_resp, t.e_err);
      req_vld     = t.rv;
      req_pld     = mk_cmd(DIR_U, 3'd7, t.addr);
      data_in_vld = t.dv;
      data_in     = mk_data(DIR_W, t.dt, t.dval);
      resp_rdy    = t.rr;
      $display("vec %0d: req=%0b data=%0b tag=%0d resp_rdy=%0b cnt=%0d", i, t.rv, t.dv, t.dt, t.rr, outstanding_cnt);
      step();
    end
    idle();

    // ---------------- full ------------------------------------------------
    do_reset();
    for (int k = 0; k < 8; k++) begin
      send_req(24'h200 + 24'(k));
      chk($sformatf("full_cmd%0d", k), read_cmd_out_pld, mk_cmd(DIR_W, 3'(k), 24'h200 + 24'(k)));
      chk($sformatf("full_cnt%0d", k), outstanding_cnt, 66'(k + 1));
    end
    chk("full_rdy", req_rdy, 0);
    send_req(24'h2FF);
    chk("full_refuse_vld", read_cmd_out_vld, 0);
    chk("full_refuse_cnt", outstanding_cnt, 8);
    send_data(DIR_W, 3'd0, 32'hF0F00000);
    chk("full_head_vld", resp_vld, 1);
    chk("full_head_pld", resp_pld, mk_data(DIR_W, 3'd0, 32'hF0F00000));
    chk("full_rdy_before_retire", req_rdy, 0);
    resp_rdy = 1'b1;
    step();
    resp_rdy = 1'b0;
    chk("full_rdy_after_retire", req_rdy, 1);
    chk("full_cnt_after_retire", outstanding_cnt, 7);
    chk("full_next_head_vld", resp_vld, 0);
    send_req(24'h2AA);
    chk("wrap_cmd_vld", read_cmd_out_vld, 1);
    chk("wrap_cmd_pld", read_cmd_out_pld, mk_cmd(DIR_W, 3'd0, 24'h2AA));
    chk("wrap_cnt", outstanding_cnt, 8);
    chk("wrap_rdy", req_rdy, 0);

    // ---------------- backpressure and concurrency ------------------------
    do_reset();
    send_req(24'h300);
    send_req(24'h301);
    send_req(24'h302);
    send_data(DIR_W, 3'd0, 32'hBEEF0000);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp_vld%0d", k), resp_vld, 1);
      chk($sformatf("bp_pld%0d", k), resp_pld, mk_data(DIR_W, 3'd0, 32'hBEEF0000));
      step();
    end
    chk("bp_cnt", outstanding_cnt, 3);
    req_vld     = 1'b1;
    req_pld     = mk_cmd(DIR_U, 3'd7, 24'h303);
    data_in_vld = 1'b1;
    data_in     = mk_data(DIR_W, 3'd1, 32'hBEEF0001);
    resp_rdy    = 1'b1;
    $display("concurrent: alloc tag3, capture tag1, retire tag0");
    step();
    idle();
    chk("cc_cmd_vld", read_cmd_out_vld, 1);
    chk("cc_cmd_pld", read_cmd_out_pld, mk_cmd(DIR_W, 3'd3, 24'h303));
    chk("cc_cnt", outstanding_cnt, 3);
    chk("cc_resp_vld", resp_vld, 1);
    chk("cc_resp_pld", resp_pld, mk_data(DIR_W, 3'd1, 32'hBEEF0001));
    resp_rdy = 1'b1;
    step();
    resp_rdy = 1'b0;
    chk("cc_head_pend_vld", resp_vld, 0);
    chk("cc_cnt2", outstanding_cnt, 2);
    send_data(DIR_W, 3'd2, 32'hBEEF0002);
    send_data(DIR_W, 3'd3, 32'hBEEF0003);
    chk("cc_t2_vld", resp_vld, 1);
    chk("cc_t2_pld", resp_pld, mk_data(DIR_W, 3'd2, 32'hBEEF0002));
    resp_rdy = 1'b1;
    step();
    chk("cc_t3_vld", resp_vld, 1);
    chk("cc_t3_pld", resp_pld, mk_data(DIR_W, 3'd3, 32'hBEEF0003));
    step();
    resp_rdy = 1'b0;
    chk("cc_drain_cnt", outstanding_cnt, 0);
    chk("cc_drain_vld", resp_vld, 0);

    // ---------------- errors ----------------------------------------------
    send_req(24'h400);                         // tag 4
    send_data(DIR_N, 3'd4, 32'h11111111);
    chk("north_resp_vld", resp_vld, 0);
    chk("north_err", err_unexp_resp, 0);
    chk("north_cnt", outstanding_cnt, 1);
    send_data(DIR_W, 3'd4, 32'h22222222);
    chk("west_resp_vld", resp_vld, 1);
    chk("west_resp_pld", resp_pld, mk_data(DIR_W, 3'd4, 32'h22222222));
    resp_rdy = 1'b1;
    step();
    resp_rdy = 1'b0;
    chk("west_cnt", outstanding_cnt, 0);
    send_data(DIR_W, 3'd5, 32'h33333333);
    chk("unexp_err", err_unexp_resp, 1);
    chk("unexp_resp_vld", resp_vld, 0);
    chk("unexp_cnt", outstanding_cnt, 0);
    step();
    chk("unexp_sticky", err_unexp_resp, 1);

    do_reset();
    send_req(24'h500);
    send_req(24'h501);
    send_req(24'h502);
    chk("pre_rst_cnt", outstanding_cnt, 3);
    do_reset();
    chk("post_rst_cnt", outstanding_cnt, 0);
    chk("post_rst_rdy", req_rdy, 1);
    chk("post_rst_err", err_unexp_resp, 0);
    send_data(DIR_W, 3'd0, 32'h44440000);
    send_data(DIR_W, 3'd1, 32'h44440001);
    send_data(DIR_W, 3'd2, 32'h44440002);
    chk("stale_err", err_unexp_resp, 1);
    chk("stale_resp_vld", resp_vld, 0);
    chk("stale_cnt", outstanding_cnt, 0);

    // ---------------- timeout ---------------------------------------------
    do_reset();
    send_req(24'h600);
    repeat (20) step();
    chk("timeout_err", timeout_err, EXP_TO);
    chk("timeout_resp_vld", resp_vld, 0);
    chk("timeout_cnt", outstanding_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
